// File: rtl/split_eval_sequencer.sv
// split_eval_sequencer: scans NUM_SPLITS split checkers through one shared
// result mux. For each split it drives split_sel, waits SETTLE_CYCLES cycles,
// then samples split_bit. It reports SAT, the first failing index and the
// failure count over a valid/ready result channel.
// Ports: clk, rst_n (async, active low); start_valid/start_ready (job request);
//        abort (cancel a running job); split_sel/split_bit (external mux);
//        busy; res_valid/res_ready, res_sat, res_fail_idx, res_fail_cnt.
// Optional macro SPLIT_EARLY_EXIT_EN: the job ends at the first failing split.
module split_eval_sequencer #(
    parameter int NUM_SPLITS    = 32,
    parameter int SETTLE_CYCLES = 2,
    parameter int IDX_W = (NUM_SPLITS > 1) ? $clog2(NUM_SPLITS) : 1,
    parameter int CNT_W = $clog2(NUM_SPLITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             abort,
    output logic [IDX_W-1:0] split_sel,
    input  logic             split_bit,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_sat,
    output logic [IDX_W-1:0] res_fail_idx,
    output logic [CNT_W-1:0] res_fail_cnt
);

    localparam int SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_SEL = IDX_W'(NUM_SPLITS - 1);
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t           state;
    logic [SET_W-1:0] settle_cnt;
    logic             sat;
    logic [IDX_W-1:0] fail_idx;
    logic [CNT_W-1:0] fail_cnt;

    // Running result if the current split_bit were taken this cycle.
    logic             nxt_sat;
    logic [IDX_W-1:0] nxt_idx;
    logic [CNT_W-1:0] nxt_cnt;
    logic             finish;

    always_comb begin
        nxt_sat = sat & split_bit;
        nxt_idx = fail_idx;
        nxt_cnt = fail_cnt;
        if (!split_bit) begin
            nxt_cnt = fail_cnt + CNT_W'(1);
            if (sat) begin
                nxt_idx = split_sel;
            end
        end
`ifdef SPLIT_EARLY_EXIT_EN
        finish = (split_sel == LAST_SEL) || !split_bit;
`else
        finish = (split_sel == LAST_SEL);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            sat          <= 1'b0;
            fail_idx     <= '0;
            fail_cnt     <= '0;
            split_sel    <= '0;
            busy         <= 1'b0;
            start_ready  <= 1'b1;
            res_valid    <= 1'b0;
            res_sat      <= 1'b0;
            res_fail_idx <= '0;
            res_fail_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_valid && start_ready) begin
                        split_sel   <= '0;
                        fail_cnt    <= '0;
                        fail_idx    <= '0;
                        sat         <= 1'b1;
                        settle_cnt  <= SET_LOAD;
                        busy        <= 1'b1;
                        start_ready <= 1'b0;
                        state       <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                        if (settle_cnt <= SET_W'(1)) begin
                            state <= SAMPLE;
                        end
                    end
                end
                SAMPLE: begin
                    // An abort in this cycle discards the sample.
                    if (abort) begin
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        sat      <= nxt_sat;
                        fail_idx <= nxt_idx;
                        fail_cnt <= nxt_cnt;
                        if (finish) begin
                            busy         <= 1'b0;
                            res_valid    <= 1'b1;
                            res_sat      <= nxt_sat;
                            res_fail_idx <= nxt_idx;
                            res_fail_cnt <= nxt_cnt;
                            state        <= DONE;
                        end else begin
                            split_sel  <= split_sel + IDX_W'(1);
                            settle_cnt <= SET_LOAD;
                            state      <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
                        end
                    end
                end
                DONE: begin
                    // start_ready rises only after the handshake edge.
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_split_eval_sequencer.sv
// tb_split_eval_sequencer: randomized jobs against a pattern-level model.
// Second instance covers the zero-settle configuration.
module tb_split_eval_sequencer;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int IW = 2;
    localparam int CW = 3;
`ifdef SPLIT_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start_valid = 1'b0;
    logic          start_ready;
    logic          abort = 1'b0;
    logic [IW-1:0] split_sel;
    logic          split_bit;
    logic          busy;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic          res_sat;
    logic [IW-1:0] res_fail_idx;
    logic [CW-1:0] res_fail_cnt;

    logic          z_start_valid = 1'b0;
    logic          z_start_ready;
    logic [IW-1:0] z_sel;
    logic          z_bit;
    logic          z_busy;
    logic          z_res_valid;
    logic          z_res_sat;
    logic [IW-1:0] z_res_fail_idx;
    logic [CW-1:0] z_res_fail_cnt;

    logic [N-1:0] pat = '1;
    logic [N-1:0] zpat = '1;

    // External split-output mux.
    assign split_bit = pat[split_sel];
    assign z_bit     = zpat[z_sel];

    split_eval_sequencer #(.NUM_SPLITS(N), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .abort(abort), .split_sel(split_sel), .split_bit(split_bit),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_sat(res_sat), .res_fail_idx(res_fail_idx),
        .res_fail_cnt(res_fail_cnt)
    );

    split_eval_sequencer #(.NUM_SPLITS(N), .SETTLE_CYCLES(0)) dut_z (
        .clk(clk), .rst_n(rst_n),
        .start_valid(z_start_valid), .start_ready(z_start_ready),
        .abort(1'b0), .split_sel(z_sel), .split_bit(z_bit),
        .busy(z_busy), .res_valid(z_res_valid), .res_ready(1'b1),
        .res_sat(z_res_sat), .res_fail_idx(z_res_fail_idx),
        .res_fail_cnt(z_res_fail_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    // Expected result of one job from the split pattern alone.
    function automatic void model(input logic [N-1:0] p, input int s,
                                  output int sat, output int idx,
                                  output int cnt, output int lat);
        int zeros;
        int first;
        zeros = 0;
        first = -1;
        for (int i = 0; i < N; i++) begin
            if (!p[i]) begin
                zeros++;
                if (first < 0) first = i;
            end
        end
        sat = (zeros == 0) ? 1 : 0;
        idx = (first < 0) ? 0 : first;
        if (EE && zeros > 0) begin
            cnt = 1;
            lat = (first + 1) * (s + 1);
        end else begin
            cnt = zeros;
            lat = N * (s + 1);
        end
    endfunction

    task automatic run_job(input logic [N-1:0] p, input int hold);
        int e_sat, e_idx, e_cnt, e_lat;
        int n, maxsel;
        bit ok;
        logic [31:0] snap;
        model(p, S, e_sat, e_idx, e_cnt, e_lat);
        pat = p;
        @(negedge clk);
        check("start_ready_idle", start_ready, 1);
        start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        n = 0;
        ok = 1'b1;
        maxsel = 0;
        while (!res_valid && n < 200) begin
            if (int'(split_sel) != n / (S + 1)) ok = 1'b0;
            if (int'(split_sel) > maxsel) maxsel = int'(split_sel);
            @(posedge clk);
            n++;
            #1;
        end
        check("latency", n, e_lat);
        check("sel_sequence", ok, 1);
        check("sel_max", maxsel, e_lat / (S + 1) - 1);
        check("res_sat", res_sat, e_sat);
        check("res_fail_idx", res_fail_idx, e_idx);
        check("res_fail_cnt", res_fail_cnt, e_cnt);
        snap = {25'd0, 1'b1, 1'b0, 1'b0, e_sat[0], e_idx[IW-1:0], e_cnt[CW-1:0]};
        start_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("done_hold",
                  {25'd0, res_valid, start_ready, busy, res_sat,
                   res_fail_idx, res_fail_cnt}, snap);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        check("handshake_no_start", {busy, res_valid, start_ready}, 3'b001);
        start_valid = 1'b0;
    endtask

    task automatic abort_test();
        logic [31:0] prior;
        prior = {res_sat, res_fail_idx, res_fail_cnt};
        pat = 4'b0101;
        @(negedge clk);
        start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_at_sel1", {busy, split_sel}, {1'b1, 2'd1});
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_idle", {busy, start_ready, res_valid}, 3'b010);
        repeat (15) @(posedge clk);
        #1;
        check("abort_no_result", res_valid, 0);
        check("abort_res_kept", {res_sat, res_fail_idx, res_fail_cnt}, prior);
    endtask

    task automatic zero_settle_job(input logic [N-1:0] p);
        int e_sat, e_idx, e_cnt, e_lat, n;
        model(p, 0, e_sat, e_idx, e_cnt, e_lat);
        zpat = p;
        @(negedge clk);
        z_start_valid = 1'b1;
        @(posedge clk);
        #1 z_start_valid = 1'b0;
        n = 0;
        while (!z_res_valid && n < 50) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("z_latency", n, e_lat);
        check("z_result", {z_res_sat, z_res_fail_idx, z_res_fail_cnt},
              {e_sat[0], e_idx[IW-1:0], e_cnt[CW-1:0]});
        @(posedge clk);
        #1;
        check("z_released", {z_res_valid, z_start_ready}, 2'b01);
    endtask

    task automatic reset_test();
        pat = '1;
        @(negedge clk);
        start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("pre_reset_sel2", {busy, split_sel}, {1'b1, 2'd2});
        rst_n = 1'b0;
        #1;
        check("async_reset",
              {split_sel, busy, res_valid, res_sat, res_fail_idx, res_fail_cnt},
              0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_ready", {start_ready, busy}, 2'b10);
        repeat (15) @(posedge clk);
        #1;
        check("post_reset_no_result", res_valid, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_state",
              {split_sel, busy, res_valid, res_sat, res_fail_idx, res_fail_cnt},
              0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_ready", start_ready, 1);

        run_job(4'b1111, 0);
        run_job(4'b0101, 5);
        for (int i = 0; i < 20; i++) begin
            run_job(N'($urandom), int'($urandom_range(0, 3)));
        end
        abort_test();
        run_job(4'b1111, 1);

        zero_settle_job(4'b1111);
        for (int i = 0; i < 6; i++) begin
            zero_settle_job(N'($urandom));
        end

        reset_test();
        run_job(4'b0110, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
